soc_debug_ocimem_ctrl: RTL and testbench
========================================

# soc_debug_ocimem_ctrl

Debug on-chip monitor memory controller for the Nios II debug path. It consumes the `jdo` payload and `take_*_ocimem_*` strobes produced by the system-clock side of the JTAG debug slave. It executes host-driven reads and writes into a 256×32 debug RAM and returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave for shift-out. A CPU-side Avalon-MM slave port shares the same RAM. JTAG-originated operations have priority over CPU operations.

## Interface
- `ADDR_W`, 8: RAM word-address width; depth = 2^ADDR_W.
- `DATA_W`, 32: RAM and `MonDReg` width; fixed at 32.
- `clk`  in  1  system clock; all logic in this domain.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  debug-slave payload, valid on any `take_*` strobe.
- `take_action_ocimem_a`  in  1  one-cycle strobe: load address, optionally read, optionally clear error.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: increment address, then read.
- `take_action_ocimem_b`  in  1  one-cycle strobe: write data at current address, then increment address.
- `avs_address`  in  ADDR_W  CPU word address.
- `avs_read`  in  1  CPU read request.
- `avs_write`  in  1  CPU write request.
- `avs_writedata`  in  32  CPU write data.
- `avs_readdata`  out  32  CPU read data, valid when `avs_read`=1 and `avs_waitrequest`=0.
- `avs_waitrequest`  out  1  CPU stall.
- `MonDReg`  out  32  monitor data register returned to the debug slave.
- `monitor_ready`  out  1  last JTAG operation completed.
- `monitor_error`  out  1  sticky overrun flag.

## Operation
- Internal state: `MonAReg[ADDR_W-1:0]`; FSM with states IDLE, JRD, JWR, CRD, CWR; one-deep JTAG pending slot (`pend_op`, `pend_jdo`).
- `jdo` decode:
  - `take_action_ocimem_a`: `MonAReg` <= `jdo[33:26]`. If `jdo[25]`=1, clear `monitor_error`. If `jdo[17]`=1, start a read (JRD). `monitor_ready` <= 0.
  - `take_no_action_ocimem_a`: `MonAReg` <= `MonAReg`+1, then JRD.
  - `take_action_ocimem_b`: `MonDReg` <= `jdo[34:3]`, then JWR.
- Strobe priority if more than one is asserted in the same cycle: `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. The lower-priority strobes are dropped and `monitor_error` is set.
- JRD: RAM read at `MonAReg`. Next cycle, `MonDReg` <= RAM data and `monitor_ready` <= 1. Then go to IDLE.
- JWR: RAM write of `MonDReg` at `MonAReg`. `MonAReg` <= `MonAReg`+1 and `monitor_ready` <= 1. Then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W: 0xFF+1 = 0x00, with no error.
- CPU read: in IDLE with `avs_read`=1 and no JTAG strobe or pending op, go to CRD. Data is returned the next cycle.
- CPU write: in IDLE with `avs_write`=1 under the same condition, go to CWR. The RAM write happens in CWR.
- If `avs_read` and `avs_write` are both asserted, the write wins.
- A JTAG strobe arriving while the FSM is not IDLE is stored in the pending slot. It is executed on the first IDLE cycle, before any CPU request.
- A strobe arriving while the pending slot is already full sets `monitor_error` and is discarded.
- `monitor_error` is sticky. It is cleared only by reset or by `take_action_ocimem_a` with `jdo[25]`=1. If the same cycle also carries an overrun, the set wins.
- Reset during any state: FSM returns to IDLE, the pending slot is emptied, and any in-flight RAM write is suppressed. RAM contents are not cleared.

## Timing
- Reset values: `MonDReg`=0, `MonAReg`=0, `monitor_ready`=0, `monitor_error`=0, `avs_readdata`=0. `avs_waitrequest`=1 while `reset`=1, and 0 in IDLE otherwise.
- JTAG read: strobe at edge N, RAM address presented in cycle N+1 (JRD). `MonDReg` and `monitor_ready`=1 are visible after edge N+2.
- JTAG write: strobe at N, RAM write during N+1 (JWR). Incremented `MonAReg` and `monitor_ready`=1 are visible after edge N+2.
- CPU read: `avs_waitrequest`=1 in the request cycle. `avs_waitrequest`=0 with valid `avs_readdata` in the cycle after (two-cycle access).
- CPU write: `avs_waitrequest`=1 in the request cycle and 0 in CWR; the write commits at the end of CWR.
- A deferred JTAG op adds exactly one cycle per CPU op in flight. A CPU request blocked by JTAG keeps `avs_waitrequest`=1 until it is granted.
- Back-to-back strobes spaced 2 cycles apart are sustained with no error.

## Test plan
- Reset, then `take_action_ocimem_b` with `jdo[34:3]`=0xDEADBEEF at address 0x10. Then `take_action_ocimem_a` with `jdo[33:26]`=0x10, `jdo[17]`=1 -> `MonDReg`=0xDEADBEEF two cycles later, `monitor_ready`=1, `MonAReg`=0x10.
- Write 0x11111111 at 0xFF, then `take_no_action_ocimem_a` -> address wraps to 0x00 and the read returns the RAM[0x00] value; `monitor_error`=0.
- CPU write 0xCAFEF00D at 0x20, then JTAG read of 0x20 -> `MonDReg`=0xCAFEF00D. JTAG write 0x5 at 0x21, then CPU read of 0x21 -> `avs_readdata`=0x5 with one wait cycle.
- `avs_read` and `take_action_ocimem_b` in the same cycle -> JTAG write is serviced first and the CPU sees 2 wait cycles. Both complete with correct data.
- Three strobes on consecutive cycles while the FSM is busy -> second is pended and third is dropped; `monitor_error`=1 and stays sticky. Then `take_action_ocimem_a` with `jdo[25]`=1 -> `monitor_error`=0.
- Assert `reset` during JWR -> target word is unchanged; outputs take their reset values; next op behaves normally.

Source files
------------

// File: rtl/soc_debug_ocimem_ctrl.sv
// soc_debug_ocimem_ctrl
// Debug on-chip monitor memory controller. Executes JTAG-host reads and
// writes into a 2^ADDR_W x 32 debug RAM and returns MonDReg,
// monitor_ready and monitor_error to the debug slave. A CPU-side
// Avalon-MM slave port shares the RAM. JTAG operations have priority over
// CPU operations.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   jdo[37:0]                  debug-slave payload, valid with any take_* strobe
//   take_action_ocimem_a       load address, optional read, optional error clear
//   take_no_action_ocimem_a    increment address, then read
//   take_action_ocimem_b       write data at address, then increment address
//   avs_address/read/write/writedata   CPU request
//   avs_readdata, avs_waitrequest      CPU response
//   MonDReg, monitor_ready, monitor_error  monitor results to the debug slave
module soc_debug_ocimem_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int unsigned DEPTH      = 1 << ADDR_W;
  // Only jdo[34:3] carries information; offsets below are within that slice.
  localparam int unsigned PAY_W      = 32;
  localparam int unsigned P_ADDR_LSB = 23;  // jdo[33:26]
  localparam int unsigned P_CLR      = 22;  // jdo[25]
  localparam int unsigned P_RD       = 14;  // jdo[17]

  typedef enum logic [2:0] {ST_IDLE, ST_JRD, ST_JWR, ST_CRD, ST_CWR} state_e;
  typedef enum logic [1:0] {OP_NONE, OP_ACT_A, OP_ACT_B, OP_NOACT_A} op_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q;
  logic [DATA_W-1:0] mon_d_q;
  logic              ready_q;
  logic              error_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pend_vld_q;
  op_e               pend_op_q;
  logic [PAY_W-1:0]  pend_pay_q;
  logic [DATA_W-1:0] mem [DEPTH];

  op_e              strb_op;
  logic [1:0]       n_strb;
  logic             strb_vld, multi_strb, is_idle;
  logic             launch_pend, launch_strb, launch, pend_store, overrun;
  logic             cpu_req;
  op_e              l_op;
  logic [PAY_W-1:0] l_pay;
  state_e           cpu_state;

  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

  // Strobe decode: a > b > no_action; losers only flag an overrun.
  always_comb begin
    strb_op = OP_NONE;
    if (take_action_ocimem_a)         strb_op = OP_ACT_A;
    else if (take_action_ocimem_b)    strb_op = OP_ACT_B;
    else if (take_no_action_ocimem_a) strb_op = OP_NOACT_A;
  end

  assign n_strb      = 2'(take_action_ocimem_a) + 2'(take_action_ocimem_b)
                     + 2'(take_no_action_ocimem_a);
  assign strb_vld    = (strb_op != OP_NONE);
  assign multi_strb  = (n_strb > 2'd1);
  assign is_idle     = (state_q == ST_IDLE);

  // A pended op always launches ahead of a fresh strobe or CPU request.
  assign launch_pend = is_idle & pend_vld_q;
  assign launch_strb = is_idle & ~pend_vld_q & strb_vld;
  assign launch      = launch_pend | launch_strb;
  assign l_op        = launch_pend ? pend_op_q  : strb_op;
  assign l_pay       = launch_pend ? pend_pay_q : jdo[34:3];
  assign pend_store  = strb_vld & ~is_idle & ~pend_vld_q;
  assign overrun     = multi_strb | (strb_vld & pend_vld_q);
  assign cpu_req     = (avs_read | avs_write) & ~strb_vld & ~pend_vld_q;
  assign cpu_state   = avs_write ? ST_CWR : ST_CRD;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state. A CPU request held off by a JTAG op is granted straight
  // from JRD/JWR so it costs only one extra wait cycle per JTAG op.
  always_comb begin
    state_d = ST_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          unique case (l_op)
            OP_ACT_A:   state_d = l_pay[P_RD] ? ST_JRD : ST_IDLE;
            OP_ACT_B:   state_d = ST_JWR;
            OP_NOACT_A: state_d = ST_JRD;
            default:    state_d = ST_IDLE;
          endcase
        end else if (cpu_req) begin
          state_d = cpu_state;
        end
      end
      ST_JRD, ST_JWR: begin
        if (cpu_req) state_d = cpu_state;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: waitrequest drops only in the CPU access cycle.
  always_comb begin
    avs_waitrequest = 1'b1;
    if (!reset) begin
      avs_waitrequest = avs_read | avs_write;
      if (state_q == ST_CRD || state_q == ST_CWR) avs_waitrequest = 1'b0;
    end
  end

  // Monitor registers, error flag, pending slot and CPU read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
      pend_vld_q <= 1'b0;
      pend_op_q  <= OP_NONE;
      pend_pay_q <= '0;
    end else begin
      if (state_q == ST_JRD) begin
        mon_d_q <= mem[mon_a_q];
        ready_q <= 1'b1;
      end
      if (state_q == ST_JWR) begin
        mon_a_q <= mon_a_q + ADDR_W'(1);
        ready_q <= 1'b1;
      end
      if (launch) begin
        ready_q <= 1'b0;
        unique case (l_op)
          OP_ACT_A:   mon_a_q <= l_pay[P_ADDR_LSB +: ADDR_W];
          OP_ACT_B:   mon_d_q <= DATA_W'(l_pay);
          OP_NOACT_A: mon_a_q <= mon_a_q + ADDR_W'(1);
          default:    ;
        endcase
      end
      // Overrun beats a same-cycle clear.
      if (overrun)
        error_q <= 1'b1;
      else if (launch && l_op == OP_ACT_A && l_pay[P_CLR])
        error_q <= 1'b0;
      if (launch_pend) pend_vld_q <= 1'b0;
      if (pend_store) begin
        pend_vld_q <= 1'b1;
        pend_op_q  <= strb_op;
        pend_pay_q <= jdo[34:3];
      end
      // Forward the JTAG write that commits on the same edge.
      if (state_d == ST_CRD) begin
        if (state_q == ST_JWR && mon_a_q == avs_address) rdata_q <= mon_d_q;
        else                                            rdata_q <= mem[avs_address];
      end
    end
  end

  // Debug RAM; a write in flight at reset is dropped, contents kept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_JWR)      mem[mon_a_q]     <= mon_d_q;
      else if (state_q == ST_CWR) mem[avs_address] <= avs_writedata;
    end
  end

  assign avs_readdata  = rdata_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_soc_debug_ocimem_ctrl.sv
// Testbench for soc_debug_ocimem_ctrl: directed scenarios with literal
// expectations, then randomized JTAG/CPU traffic, all checked every cycle
// against a transaction-level model of the monitor memory.
module tb_soc_debug_ocimem_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read, avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] MonDReg;
  logic              monitor_ready, monitor_error;

  always #5 clk = ~clk;

  soc_debug_ocimem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  localparam int DO_NONE = 0, DO_JREAD = 1, DO_JWRITE = 2, DO_CREAD = 3, DO_CWRITE = 4;
  localparam int K_A = 1, K_B = 2, K_N = 3;

  typedef struct {
    int          kind;
    logic [37:0] pay;
  } job_t;

  logic [31:0] m_mem [DEPTH];
  logic [7:0]  m_addr;
  logic [31:0] m_dreg, m_rdata;
  bit          m_ready, m_err;
  int          m_doing;
  job_t        m_slot[$];
  logic [31:0] init_val [DEPTH];

  function automatic void m_reset();
    m_addr = '0; m_dreg = '0; m_rdata = '0;
    m_ready = 1'b0; m_err = 1'b0; m_doing = DO_NONE;
    m_slot.delete();
  endfunction

  function automatic bit m_wait();
    if (reset) return 1'b1;
    if (m_doing == DO_CREAD || m_doing == DO_CWRITE) return 1'b0;
    return avs_read | avs_write;
  endfunction

  // Advance the model across one clock edge using the current inputs.
  function automatic void m_step();
    job_t strobes[$];
    job_t j;
    bit   have_job, overrun;
    int   nxt;
    if (reset) begin
      m_reset();
      return;
    end
    // Finish whatever occupied this cycle.
    case (m_doing)
      DO_JREAD:  begin m_dreg = m_mem[m_addr]; m_ready = 1'b1; end
      DO_JWRITE: begin m_mem[m_addr] = m_dreg; m_addr = m_addr + 8'd1; m_ready = 1'b1; end
      DO_CWRITE: m_mem[avs_address] = avs_writedata;
      default: ;
    endcase
    if (take_action_ocimem_a)    begin j.kind = K_A; j.pay = jdo; strobes.push_back(j); end
    if (take_action_ocimem_b)    begin j.kind = K_B; j.pay = jdo; strobes.push_back(j); end
    if (take_no_action_ocimem_a) begin j.kind = K_N; j.pay = jdo; strobes.push_back(j); end
    overrun  = strobes.size() > 1;
    have_job = 1'b0;
    nxt      = DO_NONE;
    if (m_doing == DO_NONE) begin
      if (m_slot.size() > 0) begin
        j = m_slot.pop_front(); have_job = 1'b1;
        if (strobes.size() > 0) overrun = 1'b1;
      end else if (strobes.size() > 0) begin
        j = strobes[0]; have_job = 1'b1;
      end
      if (have_job) begin
        m_ready = 1'b0;
        case (j.kind)
          K_A: begin
            m_addr = j.pay[33:26];
            if (j.pay[25]) m_err = 1'b0;
            nxt = j.pay[17] ? DO_JREAD : DO_NONE;
          end
          K_B: begin m_dreg = j.pay[34:3]; nxt = DO_JWRITE; end
          default: begin m_addr = m_addr + 8'd1; nxt = DO_JREAD; end
        endcase
      end else if (avs_read || avs_write) begin
        nxt = avs_write ? DO_CWRITE : DO_CREAD;
      end
    end else begin
      if (strobes.size() > 0) begin
        if (m_slot.size() > 0) overrun = 1'b1;
        else                   m_slot.push_back(strobes[0]);
      end else if ((m_doing == DO_JREAD || m_doing == DO_JWRITE) &&
                   m_slot.size() == 0 && (avs_read || avs_write)) begin
        nxt = avs_write ? DO_CWRITE : DO_CREAD;
      end
    end
    if (nxt == DO_CREAD) m_rdata = m_mem[avs_address];
    if (overrun) m_err = 1'b1;
    m_doing = nxt;
  endfunction

  // ---------------- checking ----------------
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void compare_model();
    chk("MonDReg", MonDReg, m_dreg);
    chk("monitor_ready", 32'(monitor_ready), 32'(m_ready));
    chk("monitor_error", 32'(monitor_error), 32'(m_err));
    chk("avs_waitrequest", 32'(avs_waitrequest), 32'(m_wait()));
    if (m_doing == DO_CREAD) chk("avs_readdata", avs_readdata, m_rdata);
  endfunction

  // Called at a negedge with inputs already driven; returns at next negedge.
  task automatic tick();
    #1;
    compare_model();
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [37:0] jdo_a(logic [7:0] a, bit rd, bit clr);
    logic [37:0] v;
    v = '0; v[33:26] = a; v[25] = clr; v[17] = rd;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(logic [31:0] d);
    logic [37:0] v;
    v = '0; v[34:3] = d;
    return v;
  endfunction

  task automatic strobe_a(logic [7:0] a, bit rd, bit clr);
    jdo = jdo_a(a, rd, clr); take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic strobe_b(logic [31:0] d);
    jdo = jdo_b(d); take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic strobe_n();
    jdo = '0; take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  initial begin
    bit cpu_busy, cpu_done;
    int r;
    reset = 1'b1; jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    m_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'h0);
    chk("rst_error", 32'(monitor_error), 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_waitreq", 32'(avs_waitrequest), 32'h1);
    tick();
    reset = 1'b0;
    tick();

    // Fill the RAM with known data through the CPU port
    for (int i = 0; i < int'(DEPTH); i++) begin
      init_val[i]   = $urandom;
      avs_address   = 8'(i);
      avs_writedata = init_val[i];
      avs_write     = 1'b1;
      tick();
      tick();
    end
    avs_write = 1'b0;
    tick();

    // JTAG write then read back at 0x10
    strobe_a(8'h10, 1'b0, 1'b0);
    strobe_b(32'hDEADBEEF);
    tick();
    chk("jwr_ready", 32'(monitor_ready), 32'h1);
    strobe_a(8'h10, 1'b1, 1'b0);
    chk("jrd_busy_ready", 32'(monitor_ready), 32'h0);
    tick();
    chk("jrd_data", MonDReg, 32'hDEADBEEF);
    chk("jrd_ready", 32'(monitor_ready), 32'h1);

    // Address wrap on write increment and on no_action increment
    strobe_a(8'hFF, 1'b0, 1'b0);
    strobe_b(32'h11111111);
    tick();
    strobe_b(32'h22222222);
    tick();
    strobe_a(8'hFF, 1'b0, 1'b0);
    strobe_n();
    tick();
    chk("wrap_read", MonDReg, 32'h22222222);
    chk("wrap_error", 32'(monitor_error), 32'h0);
    strobe_a(8'hFF, 1'b1, 1'b0);
    tick();
    chk("ff_read", MonDReg, 32'h11111111);

    // CPU write, JTAG read; JTAG write, CPU read
    avs_address = 8'h20; avs_writedata = 32'hCAFEF00D; avs_write = 1'b1;
    #1 chk("cwr_wait_req", 32'(avs_waitrequest), 32'h1);
    tick();
    #1 chk("cwr_wait_cwr", 32'(avs_waitrequest), 32'h0);
    tick();
    avs_write = 1'b0;
    strobe_a(8'h20, 1'b1, 1'b0);
    tick();
    chk("cpu_to_jtag", MonDReg, 32'hCAFEF00D);
    strobe_a(8'h21, 1'b0, 1'b0);
    strobe_b(32'h5);
    tick();
    avs_address = 8'h21; avs_read = 1'b1;
    #1 chk("crd_wait_req", 32'(avs_waitrequest), 32'h1);
    tick();
    #1 chk("crd_wait_crd", 32'(avs_waitrequest), 32'h0);
    chk("jtag_to_cpu", avs_readdata, 32'h5);
    tick();
    avs_read = 1'b0;

    // Simultaneous CPU read and JTAG write to the same word
    strobe_a(8'h40, 1'b0, 1'b0);
    jdo = jdo_b(32'hA5A50040); take_action_ocimem_b = 1'b1;
    avs_address = 8'h40; avs_read = 1'b1;
    #1 chk("col_wait0", 32'(avs_waitrequest), 32'h1);
    tick();
    take_action_ocimem_b = 1'b0;
    #1 chk("col_wait1", 32'(avs_waitrequest), 32'h1);
    tick();
    #1 chk("col_wait2", 32'(avs_waitrequest), 32'h0);
    chk("col_rdata", avs_readdata, 32'hA5A50040);
    tick();
    avs_read = 1'b0;
    strobe_a(8'h40, 1'b1, 1'b0);
    tick();
    chk("col_jread", MonDReg, 32'hA5A50040);

    // Three strobes back to back: second pended, third dropped
    chk("ovr_pre_error", 32'(monitor_error), 32'h0);
    take_action_ocimem_b = 1'b1;
    jdo = jdo_b(32'h1); tick();
    jdo = jdo_b(32'h2); tick();
    jdo = jdo_b(32'h3); tick();
    take_action_ocimem_b = 1'b0;
    chk("ovr_error_set", 32'(monitor_error), 32'h1);
    repeat (4) tick();
    chk("ovr_error_sticky", 32'(monitor_error), 32'h1);
    strobe_a(8'h00, 1'b0, 1'b1);
    chk("ovr_error_clr", 32'(monitor_error), 32'h0);

    // Reset during JWR suppresses the write
    strobe_a(8'h50, 1'b0, 1'b0);
    strobe_b(32'h12345678);
    reset = 1'b1;
    tick();
    chk("rjw_MonDReg", MonDReg, 32'h0);
    chk("rjw_ready", 32'(monitor_ready), 32'h0);
    chk("rjw_error", 32'(monitor_error), 32'h0);
    chk("rjw_readdata", avs_readdata, 32'h0);
    chk("rjw_waitreq", 32'(avs_waitrequest), 32'h1);
    reset = 1'b0;
    tick();
    strobe_a(8'h50, 1'b1, 1'b0);
    tick();
    chk("rjw_word_kept", MonDReg, init_val[8'h50]);

    // Randomized mixed traffic
    cpu_busy = 1'b0; cpu_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!cpu_busy || cpu_done) begin
        if ($urandom_range(0, 9) < 4) begin
          cpu_busy = 1'b1;
          r = $urandom_range(0, 9);
          avs_write     = (r < 4);
          avs_read      = (r >= 3);
          avs_address   = 8'($urandom);
          avs_writedata = $urandom;
        end else begin
          cpu_busy = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
        end
      end
      r = $urandom_range(0, 99);
      take_action_ocimem_a    = (r < 6);
      take_action_ocimem_b    = (r >= 5)  && (r < 12);
      take_no_action_ocimem_a = (r >= 11) && (r < 17);
      jdo   = 38'({$urandom, $urandom});
      reset = ($urandom_range(0, 399) == 0);
      cpu_done = cpu_busy && !m_wait();
      tick();
    end
    reset = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
